ethernet_rx: RTL and testbench
==============================

# ethernet_rx

Receive-side counterpart of `ethernet_tx`, working on the same N-bit beat stream. It takes beats in the same MSB-first order `ethernet_tx` produces, so an upstream `bitorder` must fix the wire order first. The block:
- locks onto preamble/SFD;
- parses destination MAC, source MAC and EtherType;
- filters on destination address;
- streams the payload out with the 32-bit FCS stripped;
- checks the FCS using the same `crc32` / `crc32_4bit` engines as the transmit path, so a TX→RX loopback passes.

## Interface
- N, 2, beat width in bits; legal values 2 and 4 only.
- clk  in  1  system clock (25/50 MHz).
- rst  in  1  reset: synchronous, active-low (clears block when 0).
- axiiv  in  1  input beat valid (carrier); a falling edge marks end of frame.
- axiid  in  N  input beat, MSB-first within each byte.
- my_mac  in  48  this FPGA's MAC address.
- axiov  out  1  payload beat valid.
- axiod  out  N  payload beat.
- src_mac  out  48  source MAC of the current/last accepted frame.
- etype  out  16  EtherType of the current/last accepted frame.
- hdr_valid  out  1  high from header-complete until the next SFD.
- frame_done  out  1  one-cycle pulse at the end of every accepted frame.
- frame_ok  out  1  qualified by frame_done: FCS matched.
- crc_err  out  1  qualified by frame_done: FCS mismatch or runt.

## Operation
- All outputs reset to 0. After reset the FSM is in IDLE.
- Window: an 8-bit window register shifts in each valid beat, `win <= {win[7-N:0], axiid}`.
- **IDLE**: on the first valid beat, move to PREAMBLE and clear the window.
- **PREAMBLE**:
  - While axiiv=1, count beats; the count saturates at 255.
  - When the window equals 8'hD5 and at least 16 preamble bits (16/N beats) have been seen, move to HEADER. The beat counter is zeroed.
  - If axiiv falls first, return to IDLE.
  - The window is never 8'hD5 during a 0x55 run for even N.
- **HEADER** (112/N beats):
  - Shift into a 112-bit register, MSB-first. Bits [111:64] = destination, [63:16] = source, [15:0] = EtherType.
  - Every header beat also feeds the CRC engine.
  - At beat 48/N the destination is complete. If it equals neither my_mac nor 48'hFFFF_FFFF_FFFF, move to DROP.
  - When the header completes: latch src_mac and etype, set hdr_valid, move to PAYLOAD.
  - If axiiv falls inside HEADER, go to IDLE with no frame_done.
- **PAYLOAD**:
  - Each beat enters a 32-bit delay line (32/N beats deep). A fill counter saturates at 32/N.
  - Once the line is full, each new beat pushes out the oldest beat. That beat goes to axiod with axiov=1 and also feeds the CRC engine.
  - As a result, the FCS is never emitted.
- **End of frame** (axiiv 1→0 while in PAYLOAD), move to DONE:
  - If the fill counter is below 32/N, set crc_err=1 (runt).
  - Otherwise, frame_ok=1 iff the delay-line contents in arrival order equal the engine's CRC output, bits [31:0] from MSB down. This is the order ethernet_tx sends its FCS.
- **DONE**: pulse frame_done with the result for one cycle, clear the CRC engine and delay line, then go to IDLE.
- **DROP**: no axiov and no frame_done. Wait for axiiv=0, then go to IDLE. hdr_valid stays 0.
- **CRC engine**: `crc32` when N=2, `crc32_4bit` when N=4. Its reset is driven by `~rst | (state==IDLE)`. Its enable is driven by header beats plus delay-line output beats.
- **Reset mid-frame**: rst=0 in any state forces IDLE with all outputs 0 on the next edge. The frame in progress is discarded.

## Timing
- axiov/axiod are registered. A payload beat appears 32/N + 1 cycles after it is presented on axiid.
- The last payload beat leaves no later than the cycle axiiv falls.
- axiov only goes high during PAYLOAD, never in the same cycle as frame_done.
- frame_done is asserted 2 cycles after the first cycle with axiiv=0: one cycle for the compare, then the registered pulse.
- frame_ok and crc_err are valid only while frame_done=1 and are 0 otherwise. They are never both 1.
- src_mac, etype and hdr_valid update one cycle after the last header beat. They hold until the next SFD.
- Back-to-back frames: a new preamble may start the cycle after axiiv falls. PREAMBLE is entered from IDLE/DONE with no lost beats beyond that first cycle.
- axiiv is assumed gap-free inside a frame. Any low cycle ends the frame.

## Test plan
- **Loopback, N=2**: drive the block from ethernet_tx with dest_mac=my_mac=48'h0123_4567_89AB, etype=16'h0800, 16-byte payload.
  - Required: 64 axiov beats with data equal to the payload.
  - Required: src_mac and etype match the transmitted values.
  - Required: frame_done with frame_ok=1 and crc_err=0.
- **Same frame, one payload bit flipped** -> identical payload beats except the flip; frame_done with crc_err=1.
- **dest=48'h0200_0000_0001 ≠ my_mac** -> axiov never high, no frame_done, hdr_valid=0. A following good broadcast frame (dest=FF..FF) is accepted with frame_ok=1.
- **Runt**: header followed by only 8 payload bits, then axiiv low -> no axiov, crc_err=1.
- **Reset mid-frame**: rst=0 for one cycle during PAYLOAD -> all outputs 0 next cycle. No frame_done. The next clean frame gives frame_ok=1.
- **N=4 build**: repeat the loopback with `crc32_4bit` -> 32 output beats; frame_ok=1.

Source files
------------

// File: rtl/ethernet_rx.sv
// Ethernet receive path on an N-bit MSB-first beat stream: SFD lock, header parse,
// destination filter, payload streaming with the FCS stripped, and FCS check.
module ethernet_rx #(
  parameter int unsigned N = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         axiiv,
  input  logic [N-1:0] axiid,
  input  logic [47:0]  my_mac,
  output logic         axiov,
  output logic [N-1:0] axiod,
  output logic [47:0]  src_mac,
  output logic [15:0]  etype,
  output logic         hdr_valid,
  output logic         frame_done,
  output logic         frame_ok,
  output logic         crc_err
);

  localparam int unsigned DLY_BEATS = 32 / N;
  localparam int unsigned HDR_BEATS = 112 / N;
  localparam int unsigned DST_BEATS = 48 / N;
  localparam int unsigned PRE_BEATS = 16 / N;
  localparam logic [31:0] POLY      = 32'h04C1_1DB7;
  localparam logic [47:0] BCAST     = 48'hFFFF_FFFF_FFFF;

  typedef enum logic [2:0] {IDLE, PREAMBLE, HEADER, PAYLOAD, DONE, DROP} state_t;

  state_t       state;
  logic [7:0]   win;
  logic [7:0]   cnt;
  logic [7:0]   fill;
  logic [63:0]  hdr;
  logic [31:0]  dly;
  logic [31:0]  crc;
  logic         res_ok;

  logic [7:0]   win_nxt;
  logic [7:0]   cnt_inc;
  logic [63:0]  hdr_nxt;
  logic [31:0]  dly_nxt;
  logic         dly_full;
  logic         crc_en;
  logic [N-1:0] crc_din;
  logic [31:0]  crc_nxt;
  logic         unused_bits;

  // CRC-32 advanced MSB-first by one N-bit beat
  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [N-1:0] d);
    logic [31:0] r;
    r = c;
    for (int i = N - 1; i >= 0; i--) begin
      r = {r[30:0], 1'b0} ^ ((r[31] ^ d[i]) ? POLY : 32'h0);
    end
    return r;
  endfunction

  // Only the last 64 header bits are kept; the destination is checked as it passes through
  always_comb begin
    win_nxt  = {win[7-N:0], axiid};
    hdr_nxt  = {hdr[63-N:0], axiid};
    dly_nxt  = {dly[31-N:0], axiid};
    cnt_inc  = (cnt == 8'd255) ? cnt : cnt + 8'd1;
    dly_full = (fill == 8'(DLY_BEATS));
    crc_en   = axiiv && ((state == HEADER) || (state == PAYLOAD && dly_full));
    crc_din  = (state == HEADER) ? axiid : dly[31 -: N];
    crc_nxt  = crc_step(crc, crc_din);
  end

  assign unused_bits = ^{hdr[63:64-N], win[7:8-N]};

  // CRC engine: held at its seed outside the header and payload phases
  always_ff @(posedge clk) begin
    if (!rst || !(state == HEADER || state == PAYLOAD)) begin
      crc <= 32'hFFFF_FFFF;
    end else if (crc_en) begin
      crc <= crc_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      win        <= '0;
      cnt        <= '0;
      fill       <= '0;
      hdr        <= '0;
      dly        <= '0;
      res_ok     <= 1'b0;
      axiov      <= 1'b0;
      axiod      <= '0;
      src_mac    <= '0;
      etype      <= '0;
      hdr_valid  <= 1'b0;
      frame_done <= 1'b0;
      frame_ok   <= 1'b0;
      crc_err    <= 1'b0;
    end else begin
      axiov      <= 1'b0;
      axiod      <= '0;
      frame_done <= 1'b0;
      frame_ok   <= 1'b0;
      crc_err    <= 1'b0;
      if (axiiv) win <= win_nxt;
      case (state)
        IDLE: begin
          if (axiiv) begin
            state <= PREAMBLE;
            win   <= '0;
            cnt   <= '0;
          end
        end
        PREAMBLE: begin
          if (!axiiv) begin
            state <= IDLE;
          end else begin
            cnt <= cnt_inc;
            if (win_nxt == 8'hD5 && cnt_inc >= 8'(PRE_BEATS)) begin
              state     <= HEADER;
              cnt       <= '0;
              hdr_valid <= 1'b0;
            end
          end
        end
        HEADER: begin
          if (!axiiv) begin
            state <= IDLE;
          end else begin
            hdr <= hdr_nxt;
            cnt <= cnt_inc;
            if (cnt == 8'(DST_BEATS - 1) && hdr_nxt[47:0] != my_mac && hdr_nxt[47:0] != BCAST) begin
              state <= DROP;
            end else if (cnt == 8'(HDR_BEATS - 1)) begin
              src_mac   <= hdr_nxt[63:16];
              etype     <= hdr_nxt[15:0];
              hdr_valid <= 1'b1;
              fill      <= '0;
              state     <= PAYLOAD;
            end
          end
        end
        PAYLOAD: begin
          if (!axiiv) begin
            // A runt never fills the delay line, so it can never compare equal
            res_ok <= dly_full && (dly == ~crc);
            state  <= DONE;
          end else begin
            dly <= dly_nxt;
            if (dly_full) begin
              axiov <= 1'b1;
              axiod <= dly[31 -: N];
            end else begin
              fill <= fill + 8'd1;
            end
          end
        end
        DONE: begin
          frame_done <= 1'b1;
          frame_ok   <= res_ok;
          crc_err    <= !res_ok;
          dly        <= '0;
          fill       <= '0;
          if (axiiv) begin
            state <= PREAMBLE;
            win   <= '0;
            cnt   <= '0;
          end else begin
            state <= IDLE;
          end
        end
        DROP: begin
          if (!axiiv) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ethernet_rx.sv
// Bench for ethernet_rx: random frames built from a byte-level model, checked on
// an N=2 and an N=4 instance.
module tb_ethernet_rx;

  typedef logic [7:0] bq_t[$];
  typedef logic [3:0] nq_t[$];

  localparam logic [47:0] MY_MAC = 48'h0123_4567_89AB;

  logic clk = 1'b0;
  logic rst;
  logic axiiv2, axiiv4;
  logic [1:0] axiid2;
  logic [3:0] axiid4;
  logic axiov2, axiov4;
  logic [1:0] axiod2;
  logic [3:0] axiod4;
  logic [47:0] src_mac2, src_mac4;
  logic [15:0] etype2, etype4;
  logic hdr_valid2, hdr_valid4, frame_done2, frame_done4;
  logic frame_ok2, frame_ok4, crc_err2, crc_err4;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int low_cyc, pay_cyc;
  nq_t got2, got4;
  int done2_n, done4_n, done2_cyc, ov2_cyc, last_ov2_cyc;
  logic ok2, err2, ok4, err4;

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ethernet_rx #(.N(2)) d2 (
    .clk(clk), .rst(rst), .axiiv(axiiv2), .axiid(axiid2), .my_mac(MY_MAC),
    .axiov(axiov2), .axiod(axiod2), .src_mac(src_mac2), .etype(etype2),
    .hdr_valid(hdr_valid2), .frame_done(frame_done2), .frame_ok(frame_ok2), .crc_err(crc_err2));

  ethernet_rx #(.N(4)) d4 (
    .clk(clk), .rst(rst), .axiiv(axiiv4), .axiid(axiid4), .my_mac(MY_MAC),
    .axiov(axiov4), .axiod(axiod4), .src_mac(src_mac4), .etype(etype4),
    .hdr_valid(hdr_valid4), .frame_done(frame_done4), .frame_ok(frame_ok4), .crc_err(crc_err4));

  // Output monitors plus always-true protocol properties
  always @(negedge clk) begin
    if (axiov2) begin
      if (got2.size() == 0) ov2_cyc = cyc;
      last_ov2_cyc = cyc;
      got2.push_back(4'(axiod2));
    end
    if (frame_done2) begin
      done2_n++; ok2 = frame_ok2; err2 = crc_err2; done2_cyc = cyc;
    end
    if (axiov2 && frame_done2) begin
      checks++; errors++; $display("FAIL axiov_with_done: axiov=1 frame_done=1 at cycle %0d", cyc);
    end
    if (frame_ok2 && crc_err2) begin
      checks++; errors++; $display("FAIL ok_and_err: both high at cycle %0d", cyc);
    end
    if ((frame_ok2 || crc_err2) && !frame_done2) begin
      checks++; errors++; $display("FAIL unqualified_result: ok=%b err=%b without frame_done", frame_ok2, crc_err2);
    end
  end

  always @(negedge clk) begin
    if (axiov4) got4.push_back(axiod4);
    if (frame_done4) begin
      done4_n++; ok4 = frame_ok4; err4 = crc_err4;
    end
  end

  function automatic logic [31:0] fcs_of(input bq_t b);
    logic [31:0] c = 32'hFFFF_FFFF;
    logic fb;
    foreach (b[i]) begin
      for (int j = 7; j >= 0; j--) begin
        fb = c[31] ^ b[i][j];
        c = {c[30:0], 1'b0} ^ (fb ? 32'h04C1_1DB7 : 32'h0);
      end
    end
    return ~c;
  endfunction

  function automatic bq_t build(input logic [47:0] dst, input logic [47:0] src,
                                input logic [15:0] et, input bq_t pay);
    bq_t body, fr;
    logic [31:0] f;
    for (int i = 5; i >= 0; i--) body.push_back(dst[8*i +: 8]);
    for (int i = 5; i >= 0; i--) body.push_back(src[8*i +: 8]);
    body.push_back(et[15:8]);
    body.push_back(et[7:0]);
    foreach (pay[i]) body.push_back(pay[i]);
    f = fcs_of(body);
    for (int i = 0; i < 7; i++) fr.push_back(8'h55);
    fr.push_back(8'hD5);
    foreach (body[i]) fr.push_back(body[i]);
    for (int i = 3; i >= 0; i--) fr.push_back(f[8*i +: 8]);
    return fr;
  endfunction

  function automatic nq_t beats_of(input bq_t pay, input int n);
    nq_t q;
    logic [7:0] b;
    foreach (pay[i]) begin
      b = pay[i];
      for (int k = 0; k < 8 / n; k++) begin
        if (n == 2) q.push_back(4'(b[7-2*k -: 2]));
        else q.push_back(b[7-4*k -: 4]);
      end
    end
    return q;
  endfunction

  function automatic bq_t rand_bytes(input int len);
    bq_t q;
    for (int i = 0; i < len; i++) q.push_back(8'($urandom));
    return q;
  endfunction

  // Drives a frame into the N=2 instance; abort_at>=0 pulses reset at that byte instead
  task automatic drive2(input bq_t fr, input int abort_at);
    logic [7:0] b;
    foreach (fr[i]) begin
      if (i == abort_at) begin
        @(negedge clk); axiiv2 = 1'b0; rst = 1'b0;
        return;
      end
      b = fr[i];
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        if (i == 22 && k == 0) pay_cyc = cyc;
        axiiv2 = 1'b1;
        axiid2 = b[7-2*k -: 2];
      end
    end
    @(negedge clk); axiiv2 = 1'b0; axiid2 = '0; low_cyc = cyc;
  endtask

  task automatic drive4(input bq_t fr);
    logic [7:0] b;
    foreach (fr[i]) begin
      b = fr[i];
      for (int k = 0; k < 2; k++) begin
        @(negedge clk); axiiv4 = 1'b1; axiid4 = b[7-4*k -: 4];
      end
    end
    @(negedge clk); axiiv4 = 1'b0; axiid4 = '0;
  endtask

  task automatic clear_mon();
    got2.delete(); got4.delete();
    done2_n = 0; done4_n = 0; done2_cyc = -1; ov2_cyc = -1; last_ov2_cyc = -1;
    ok2 = 1'b0; err2 = 1'b0; ok4 = 1'b0; err4 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; axiiv2 = 1'b0; axiid2 = '0; axiiv4 = 1'b0; axiid4 = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({axiov2, axiod2, src_mac2, etype2, hdr_valid2, frame_done2, frame_ok2, crc_err2} !== '0) begin
      errors++; $display("FAIL reset_n2: outputs not all zero, src_mac=%h etype=%h", src_mac2, etype2);
    end
    checks++;
    if ({axiov4, axiod4, src_mac4, etype4, hdr_valid4, frame_done4, frame_ok4, crc_err4} !== '0) begin
      errors++; $display("FAIL reset_n4: outputs not all zero, src_mac=%h etype=%h", src_mac4, etype4);
    end
    rst = 1'b1;
    @(negedge clk);
    clear_mon();
  endtask

  task automatic test_loopback();
    bq_t pay = rand_bytes(16);
    logic [47:0] src = {16'($urandom), 32'($urandom)};
    nq_t exp = beats_of(pay, 2);
    int bad = 0;
    clear_mon();
    drive2(build(MY_MAC, src, 16'h0800, pay), -1);
    repeat (6) @(negedge clk);
    checks++;
    if (got2.size() !== 64) begin errors++; $display("FAIL loop_beats: got %0d want 64", got2.size()); end
    for (int i = 0; i < exp.size() && i < got2.size(); i++) if (got2[i] !== exp[i]) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL loop_data: %0d beats differ, want 0", bad); end
    checks++;
    if (src_mac2 !== src || etype2 !== 16'h0800) begin
      errors++; $display("FAIL loop_hdr: src=%h etype=%h want %h 0800", src_mac2, etype2, src);
    end
    checks++;
    if (hdr_valid2 !== 1'b1) begin errors++; $display("FAIL loop_hdr_valid: got %b want 1", hdr_valid2); end
    checks++;
    if (done2_n !== 1 || ok2 !== 1'b1 || err2 !== 1'b0) begin
      errors++; $display("FAIL loop_result: done=%0d ok=%b err=%b want 1 1 0", done2_n, ok2, err2);
    end
    checks++;
    if (done2_cyc !== low_cyc + 2) begin
      errors++; $display("FAIL loop_done_time: cycle %0d want %0d", done2_cyc, low_cyc + 2);
    end
    checks++;
    if (ov2_cyc !== pay_cyc + 17) begin
      errors++; $display("FAIL loop_latency: first beat cycle %0d want %0d", ov2_cyc, pay_cyc + 17);
    end
    checks++;
    if (last_ov2_cyc !== low_cyc) begin
      errors++; $display("FAIL loop_last_beat: cycle %0d want %0d", last_ov2_cyc, low_cyc);
    end
  endtask

  task automatic test_bitflip();
    bq_t pay = rand_bytes(16);
    bq_t fr = build(MY_MAC, 48'h0A0B_0C0D_0E0F, 16'h0800, pay);
    int pos = int'($urandom_range(0, 15));
    int bit_i = int'($urandom_range(0, 7));
    nq_t exp;
    int bad = 0;
    fr[22 + pos][bit_i] = ~fr[22 + pos][bit_i];
    pay[pos][bit_i] = ~pay[pos][bit_i];
    exp = beats_of(pay, 2);
    clear_mon();
    drive2(fr, -1);
    repeat (6) @(negedge clk);
    for (int i = 0; i < exp.size() && i < got2.size(); i++) if (got2[i] !== exp[i]) bad++;
    checks++;
    if (got2.size() !== 64 || bad != 0) begin
      errors++; $display("FAIL flip_data: %0d beats, %0d differ; want 64, 0", got2.size(), bad);
    end
    checks++;
    if (done2_n !== 1 || ok2 !== 1'b0 || err2 !== 1'b1) begin
      errors++; $display("FAIL flip_result: done=%0d ok=%b err=%b want 1 0 1", done2_n, ok2, err2);
    end
  endtask

  task automatic test_filter();
    bq_t pay = rand_bytes(int'($urandom_range(1, 24)));
    nq_t exp = beats_of(pay, 2);
    clear_mon();
    drive2(build(48'h0200_0000_0001, 48'h1111_2222_3333, 16'h0806, rand_bytes(12)), -1);
    repeat (6) @(negedge clk);
    checks++;
    if (got2.size() !== 0 || done2_n !== 0 || hdr_valid2 !== 1'b0) begin
      errors++; $display("FAIL filter_drop: beats=%0d done=%0d hdr_valid=%b want 0 0 0", got2.size(), done2_n, hdr_valid2);
    end
    clear_mon();
    drive2(build(48'hFFFF_FFFF_FFFF, 48'h4444_5555_6666, 16'h0806, pay), -1);
    repeat (6) @(negedge clk);
    checks++;
    if (got2 !== exp || done2_n !== 1 || ok2 !== 1'b1 || err2 !== 1'b0) begin
      errors++; $display("FAIL filter_bcast: beats=%0d want %0d done=%0d ok=%b err=%b", got2.size(), exp.size(), done2_n, ok2, err2);
    end
    checks++;
    if (src_mac2 !== 48'h4444_5555_6666 || etype2 !== 16'h0806) begin
      errors++; $display("FAIL filter_hdr: src=%h etype=%h", src_mac2, etype2);
    end
  endtask

  task automatic test_runt();
    bq_t fr = build(MY_MAC, 48'h0000_1111_2222, 16'h0800, rand_bytes(1));
    repeat (4) void'(fr.pop_back());
    clear_mon();
    drive2(fr, -1);
    repeat (6) @(negedge clk);
    checks++;
    if (got2.size() !== 0 || done2_n !== 1 || ok2 !== 1'b0 || err2 !== 1'b1) begin
      errors++; $display("FAIL runt: beats=%0d done=%0d ok=%b err=%b want 0 1 0 1", got2.size(), done2_n, ok2, err2);
    end
  endtask

  task automatic test_mid_reset();
    bq_t pay = rand_bytes(12);
    nq_t exp = beats_of(pay, 2);
    clear_mon();
    drive2(build(MY_MAC, 48'h7777_8888_9999, 16'h86DD, rand_bytes(20)), 34);
    @(negedge clk);
    checks++;
    if ({axiov2, axiod2, src_mac2, etype2, hdr_valid2, frame_done2, frame_ok2, crc_err2} !== '0) begin
      errors++; $display("FAIL midreset_outputs: axiov=%b src=%h etype=%h hdr_valid=%b", axiov2, src_mac2, etype2, hdr_valid2);
    end
    rst = 1'b1;
    repeat (6) @(negedge clk);
    checks++;
    if (done2_n !== 0) begin errors++; $display("FAIL midreset_done: got %0d want 0", done2_n); end
    clear_mon();
    drive2(build(MY_MAC, 48'h7777_8888_9999, 16'h86DD, pay), -1);
    repeat (6) @(negedge clk);
    checks++;
    if (got2 !== exp || done2_n !== 1 || ok2 !== 1'b1) begin
      errors++; $display("FAIL midreset_next: beats=%0d want %0d done=%0d ok=%b", got2.size(), exp.size(), done2_n, ok2);
    end
  endtask

  task automatic test_back_to_back();
    bq_t pa = rand_bytes(int'($urandom_range(1, 20)));
    bq_t pb = rand_bytes(int'($urandom_range(1, 20)));
    nq_t exp = beats_of(pa, 2);
    nq_t eb = beats_of(pb, 2);
    foreach (eb[i]) exp.push_back(eb[i]);
    clear_mon();
    drive2(build(MY_MAC, 48'hAAAA_0000_0001, 16'h0800, pa), -1);
    drive2(build(48'hFFFF_FFFF_FFFF, 48'hAAAA_0000_0002, 16'h0801, pb), -1);
    repeat (6) @(negedge clk);
    checks++;
    if (got2 !== exp) begin errors++; $display("FAIL b2b_data: beats=%0d want %0d", got2.size(), exp.size()); end
    checks++;
    if (done2_n !== 2 || ok2 !== 1'b1 || src_mac2 !== 48'hAAAA_0000_0002 || etype2 !== 16'h0801) begin
      errors++; $display("FAIL b2b_result: done=%0d ok=%b src=%h etype=%h", done2_n, ok2, src_mac2, etype2);
    end
  endtask

  task automatic test_loopback_n4();
    bq_t pay = rand_bytes(16);
    nq_t exp = beats_of(pay, 4);
    clear_mon();
    drive4(build(MY_MAC, 48'h0102_0304_0506, 16'h0800, pay));
    repeat (6) @(negedge clk);
    checks++;
    if (got4.size() !== 32 || got4 !== exp) begin
      errors++; $display("FAIL n4_data: beats=%0d want 32 (data match %b)", got4.size(), got4 == exp);
    end
    checks++;
    if (done4_n !== 1 || ok4 !== 1'b1 || err4 !== 1'b0 || src_mac4 !== 48'h0102_0304_0506 || etype4 !== 16'h0800) begin
      errors++; $display("FAIL n4_result: done=%0d ok=%b err=%b src=%h etype=%h", done4_n, ok4, err4, src_mac4, etype4);
    end
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_bitflip();
    test_filter();
    test_runt();
    test_mid_reset();
    test_back_to_back();
    test_loopback_n4();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
